// File: rtl/mgt_01_wb_arbiter.sv
// Writeback arbiter: merges ALU, LSU and MDU results onto one register-file write port.
// ALU normally has priority; slow sources that lose too long are forced through.
package mgt_01_wb_arbiter_pkg;
    typedef enum logic [4:0] {
        X0,  X1,  X2,  X3,  X4,  X5,  X6,  X7,  X8,  X9,  X10, X11, X12, X13, X14, X15,
        X16, X17, X18, X19, X20, X21, X22, X23, X24, X25, X26, X27, X28, X29, X30, X31
    } i_register_e;
    typedef logic [31:0] data_bus_t;
endpackage

module mgt_01_wb_arbiter
    import mgt_01_wb_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clk_en_i,
    input  logic        alu_valid_i,
    output logic        alu_ready_o,
    input  i_register_e alu_rd_i,
    input  data_bus_t   alu_data_i,
    input  logic        lsu_valid_i,
    output logic        lsu_ready_o,
    input  i_register_e lsu_rd_i,
    input  data_bus_t   lsu_data_i,
    input  logic        mdu_valid_i,
    output logic        mdu_ready_o,
    input  i_register_e mdu_rd_i,
    input  data_bus_t   mdu_data_i,
    output logic        we_o,
    output i_register_e w_iaddr_o,
    output data_bus_t   wr_idata_o,
    output logic [1:0]  grant_src_o
);
    localparam int CW = $clog2(STARVE_LIMIT + 2);

    typedef enum logic [1:0] {
        SRC_NONE = 2'b00,
        SRC_ALU  = 2'b01,
        SRC_LSU  = 2'b10,
        SRC_MDU  = 2'b11
    } src_e;

    src_e        grant;
    src_e        rr_pick;
    logic [1:0]  slow_valid;
    logic [1:0]  slow_granted;
    logic [1:0]  slow_starved;
    i_register_e sel_rd;
    data_bus_t   sel_data;

    logic        we_q;
    i_register_e w_iaddr_q;
    data_bus_t   wr_idata_q;
    src_e        grant_src_q;
    logic        rr_last_mdu_q;

    // Slow source index 0 is the LSU, index 1 the MDU.
    assign slow_valid   = {mdu_valid_i, lsu_valid_i};
    assign slow_granted = {grant == SRC_MDU, grant == SRC_LSU};

    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_slow
        logic [CW-1:0] wait_q;
        logic [CW-1:0] wait_d;

        assign slow_starved[gi] = slow_valid[gi] && (wait_q == CW'(STARVE_LIMIT));

        always_comb begin
            wait_d = '0;
            if (slow_valid[gi] && !slow_granted[gi]) begin
                wait_d = (wait_q == CW'(STARVE_LIMIT)) ? wait_q : wait_q + CW'(1);
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                wait_q <= '0;
            end else if (clk_en_i) begin
                wait_q <= wait_d;
            end
        end
    end

    assign rr_pick = rr_last_mdu_q ? SRC_LSU : SRC_MDU;

    always_comb begin
        grant = SRC_NONE;
        if (!rst_i && clk_en_i) begin
            if (&slow_starved)         grant = rr_pick;
            else if (slow_starved[0])  grant = SRC_LSU;
            else if (slow_starved[1])  grant = SRC_MDU;
            else if (alu_valid_i)      grant = SRC_ALU;
            else if (&slow_valid)      grant = rr_pick;
            else if (slow_valid[0])    grant = SRC_LSU;
            else if (slow_valid[1])    grant = SRC_MDU;
        end
    end

    assign alu_ready_o = (grant == SRC_ALU);
    assign lsu_ready_o = (grant == SRC_LSU);
    assign mdu_ready_o = (grant == SRC_MDU);

    always_comb begin
        sel_rd   = X0;
        sel_data = '0;
        case (grant)
            SRC_ALU: begin sel_rd = alu_rd_i; sel_data = alu_data_i; end
            SRC_LSU: begin sel_rd = lsu_rd_i; sel_data = lsu_data_i; end
            SRC_MDU: begin sel_rd = mdu_rd_i; sel_data = mdu_data_i; end
            default: begin sel_rd = X0;       sel_data = '0;         end
        endcase
    end

    // Reset wins over clk_en, so a transfer coinciding with a reset edge is dropped.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            we_q          <= 1'b0;
            w_iaddr_q     <= X0;
            wr_idata_q    <= '0;
            grant_src_q   <= SRC_NONE;
            rr_last_mdu_q <= 1'b1;
        end else if (clk_en_i) begin
            grant_src_q <= grant;
            we_q        <= (grant != SRC_NONE) && (sel_rd != X0);
            if (grant != SRC_NONE) begin
                w_iaddr_q  <= sel_rd;
                wr_idata_q <= sel_data;
            end
            if (grant == SRC_LSU)      rr_last_mdu_q <= 1'b0;
            else if (grant == SRC_MDU) rr_last_mdu_q <= 1'b1;
        end
    end

    assign we_o        = we_q;
    assign w_iaddr_o   = w_iaddr_q;
    assign wr_idata_o  = wr_idata_q;
    assign grant_src_o = grant_src_q;
endmodule

// File: tb/tb_mgt_01_wb_arbiter.sv
// Random and directed stimulus against a rule-level arbitration model; expected writeback
// results are queued by the driver and checked by an independent monitor after each edge.
module tb_mgt_01_wb_arbiter;
    import mgt_01_wb_arbiter_pkg::*;

    localparam int LIMIT = 4;

    logic        clk;
    logic        rst_i, clk_en_i;
    logic        alu_valid_i, lsu_valid_i, mdu_valid_i;
    logic        alu_ready_o, lsu_ready_o, mdu_ready_o;
    i_register_e alu_rd_i, lsu_rd_i, mdu_rd_i;
    data_bus_t   alu_data_i, lsu_data_i, mdu_data_i;
    logic        we_o;
    i_register_e w_iaddr_o;
    data_bus_t   wr_idata_o;
    logic [1:0]  grant_src_o;

    mgt_01_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk_i(clk), .rst_i(rst_i), .clk_en_i(clk_en_i),
        .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o), .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i),
        .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o), .lsu_rd_i(lsu_rd_i), .lsu_data_i(lsu_data_i),
        .mdu_valid_i(mdu_valid_i), .mdu_ready_o(mdu_ready_o), .mdu_rd_i(mdu_rd_i), .mdu_data_i(mdu_data_i),
        .we_o(we_o), .w_iaddr_o(w_iaddr_o), .wr_idata_o(wr_idata_o), .grant_src_o(grant_src_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [1:0]  src;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference state: wait counts per slow source, last slow winner (2=LSU, 3=MDU), outputs.
    int   m_wait[2];
    int   m_rr_last = 3;
    exp_t m_out = '{we: 1'b0, addr: 5'd0, data: 32'd0, src: 2'd0};

    function automatic int rr_winner();
        return (m_rr_last == 3) ? 2 : 3;
    endfunction

    task automatic step(input logic r, input logic en,
                        input logic av, input logic [4:0] ard, input logic [31:0] ad,
                        input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                        input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                        output logic [2:0] rdy_seen);
        int         win;
        logic [2:0] exp_rdy;
        logic [4:0] rd;
        logic [31:0] dat;
        bit         s_l, s_m;
        @(negedge clk);
        rst_i = r; clk_en_i = en;
        alu_valid_i = av; alu_rd_i = i_register_e'(ard); alu_data_i = ad;
        lsu_valid_i = lv; lsu_rd_i = i_register_e'(lrd); lsu_data_i = ld;
        mdu_valid_i = mv; mdu_rd_i = i_register_e'(mrd); mdu_data_i = md;
        #1;
        win = 0;
        if (!r && en) begin
            s_l = lv && (m_wait[0] == LIMIT);
            s_m = mv && (m_wait[1] == LIMIT);
            if (s_l && s_m)     win = rr_winner();
            else if (s_l)       win = 2;
            else if (s_m)       win = 3;
            else if (av)        win = 1;
            else if (lv && mv)  win = rr_winner();
            else if (lv)        win = 2;
            else if (mv)        win = 3;
        end
        exp_rdy = (win == 1) ? 3'b100 : (win == 2) ? 3'b010 : (win == 3) ? 3'b001 : 3'b000;
        rdy_seen = {alu_ready_o, lsu_ready_o, mdu_ready_o};
        total++;
        if (rdy_seen !== exp_rdy) begin
            bad++;
            $display("FAIL ready: got alu/lsu/mdu=%b want %b (t=%0t)", rdy_seen, exp_rdy, $time);
        end
        if (r) begin
            m_out = '{we: 1'b0, addr: 5'd0, data: 32'd0, src: 2'd0};
            m_wait[0] = 0; m_wait[1] = 0; m_rr_last = 3;
        end else if (en) begin
            if (win != 0) begin
                rd  = (win == 1) ? ard : (win == 2) ? lrd : mrd;
                dat = (win == 1) ? ad  : (win == 2) ? ld  : md;
                m_out.addr = rd; m_out.data = dat; m_out.src = 2'(win); m_out.we = (rd != 5'd0);
                if (win >= 2) m_rr_last = win;
            end else begin
                m_out.we = 1'b0; m_out.src = 2'd0;
            end
            m_wait[0] = (lv && win != 2) ? ((m_wait[0] + 1 > LIMIT) ? LIMIT : m_wait[0] + 1) : 0;
            m_wait[1] = (mv && win != 3) ? ((m_wait[1] + 1 > LIMIT) ? LIMIT : m_wait[1] + 1) : 0;
        end
        q.push_back(m_out);
    endtask

    // Monitor: after every edge, compare the registered outputs with the oldest expectation.
    initial begin
        exp_t       e;
        logic [4:0] a;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                a = w_iaddr_o;
                total++;
                if (we_o !== e.we || a !== e.addr || wr_idata_o !== e.data || grant_src_o !== e.src) begin
                    bad++;
                    $display("FAIL wb_out: got we=%b addr=%0d data=%h src=%b want we=%b addr=%0d data=%h src=%b (t=%0t)",
                             we_o, a, wr_idata_o, grant_src_o, e.we, e.addr, e.data, e.src, $time);
                end else begin
                    $display("wb cycle t=%0t we=%b addr=%0d data=%h src=%b", $time, we_o, a, wr_idata_o, grant_src_o);
                end
            end
        end
    end

    task automatic directed_check(input string name, input logic [2:0] got, input logic [2:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got alu/lsu/mdu=%b want %b", name, got, want);
        end
    endtask

    initial begin
        logic [2:0] rdy;
        logic       r, en, av, lv, mv;
        logic [4:0] ard, lrd, mrd;
        rst_i = 1'b1; clk_en_i = 1'b0;
        alu_valid_i = 1'b0; lsu_valid_i = 1'b0; mdu_valid_i = 1'b0;
        alu_rd_i = X0; lsu_rd_i = X0; mdu_rd_i = X0;
        alu_data_i = '0; lsu_data_i = '0; mdu_data_i = '0;

        // Reset, including with clk_en low.
        step(1, 0, 1, 5'd5, 32'hDEADBEEF, 1, 5'd6, 32'h1, 1, 5'd7, 32'h2, rdy);
        directed_check("ready_in_reset", rdy, 3'b000);
        step(1, 1, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, rdy);

        // ALU stream to x5.
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, rdy);
            directed_check("alu_stream", rdy, 3'b100);
        end

        // LSU/MDU tie from reset alternates starting with LSU.
        step(1, 1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, rdy);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 5'd0, 32'h0, 1, 5'd10, 32'hA0 + i, 1, 5'd11, 32'hB0 + i, rdy);
            directed_check("rr_alternate", rdy, (i % 2 == 0) ? 3'b010 : 3'b001);
        end

        // ALU hogging; LSU forced through after STARVE_LIMIT losses, ALU regranted next.
        step(1, 1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, rdy);
        for (int i = 0; i < 7; i++) begin
            step(0, 1, 1, 5'd1, 32'h100 + i, 1, 5'd2, 32'h200 + i, 0, 5'd0, 32'h0, rdy);
            directed_check("starve", rdy, (i == LIMIT) ? 3'b010 : 3'b100);
        end

        // MDU write to X0: consumed, grant recorded, no write enable.
        step(0, 1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd0, 32'h1234, rdy);
        directed_check("mdu_x0", rdy, 3'b001);

        // Pending write frozen through three disabled cycles.
        step(0, 1, 1, 5'd9, 32'hCAFEF00D, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, rdy);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 5'd3, 32'h33, 1, 5'd4, 32'h44, 1, 5'd8, 32'h88, rdy);
            directed_check("clk_en_low", rdy, 3'b000);
        end

        // LSU transfer immediately followed by reset: no ghost write.
        step(0, 1, 0, 5'd0, 32'h0, 1, 5'd12, 32'h5555, 0, 5'd0, 32'h0, rdy);
        step(1, 1, 0, 5'd0, 32'h0, 1, 5'd12, 32'h5555, 0, 5'd0, 32'h0, rdy);
        step(0, 1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, rdy);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            r   = ($urandom_range(0, 99) < 2);
            en  = ($urandom_range(0, 99) < 85);
            av  = ($urandom_range(0, 99) < 55);
            lv  = ($urandom_range(0, 99) < 50);
            mv  = ($urandom_range(0, 99) < 50);
            ard = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            lrd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            mrd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            step(r, en, av, ard, $urandom, lv, lrd, $urandom, mv, mrd, $urandom, rdy);
        end

        @(posedge clk);
        #3;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expectations want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
